// File: rtl/imem_loader_if.sv
// Byte-stream and memory-write-port bundle for imem_loader.
// The master modport belongs to the byte source and the memory/core observer.
// The slave modport belongs to the loader itself.
interface imem_loader_if;
    logic        start;
    logic [7:0]  len_words;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        core_reset;
    logic        busy;
    logic        done;
    logic        error;

    modport master (
        output start,
        output len_words,
        output byte_valid,
        output byte_data,
        input  byte_ready,
        input  wr_en,
        input  wr_addr,
        input  wr_data,
        input  core_reset,
        input  busy,
        input  done,
        input  error
    );

    modport slave (
        input  start,
        input  len_words,
        input  byte_valid,
        input  byte_data,
        output byte_ready,
        output wr_en,
        output wr_addr,
        output wr_data,
        output core_reset,
        output busy,
        output done,
        output error
    );
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader.
// Packs a little-endian byte stream into 32-bit words and writes them to the
// instruction memory, starting at address 0, while holding the core in reset.
// The core is released only after every requested word has been written.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN. When it is defined, a trailing
// checksum byte (modulo-256 sum of all data bytes) must match before the core is released.
module imem_loader #(
    parameter int unsigned MEM_BYTES = 32
) (
    input  logic          clk,
    input  logic          reset,
    imem_loader_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WRITE,
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHK,
`endif
        S_DONE,
        S_ERR
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [7:0]  r_len;
    logic [7:0]  r_word_cnt;
    logic [1:0]  r_byte_idx;
    logic [23:0] r_word_lo;
    logic [31:0] r_wr_addr;
    logic [31:0] r_wr_data;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]  r_sum;
`endif

    logic        w_byte_ready;
    logic        w_wr_en;
    logic        w_busy;
    logic        w_done;
    logic        w_error;
    logic        w_core_reset;
    logic        w_xfer;
    logic        w_can_start;
    logic        w_len_bad;
    logic        w_last_word;
    logic [31:0] w_len_bytes;

    assign w_xfer      = bus.byte_valid && w_byte_ready;
    assign w_len_bytes = {22'd0, bus.len_words, 2'b00};
    assign w_len_bad   = (bus.len_words == 8'd0) || (w_len_bytes > MEM_BYTES);
    assign w_can_start = bus.start &&
                         ((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR));
    assign w_last_word = ((r_word_cnt + 8'd1) == r_len);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state selection and state-decoded outputs
    always_comb begin
        w_state_nxt  = r_state;
        w_byte_ready = 1'b0;
        w_wr_en      = 1'b0;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        w_error      = 1'b0;
        w_core_reset = 1'b1;
        case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
                w_done       = (r_state == S_DONE);
                w_error      = (r_state == S_ERR);
                w_core_reset = (r_state != S_DONE);
                if (w_can_start) begin
                    w_state_nxt = w_len_bad ? S_ERR : S_LOAD;
                end
            end
            S_LOAD: begin
                w_busy       = 1'b1;
                w_byte_ready = 1'b1;
                if (w_xfer && (r_byte_idx == 2'd3)) begin
                    w_state_nxt = S_WRITE;
                end
            end
            S_WRITE: begin
                w_busy  = 1'b1;
                w_wr_en = 1'b1;
                if (w_last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    w_state_nxt = S_CHK;
`else
                    w_state_nxt = S_DONE;
`endif
                end else begin
                    w_state_nxt = S_LOAD;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHK: begin
                w_busy       = 1'b1;
                w_byte_ready = 1'b1;
                if (w_xfer) begin
                    w_state_nxt = (bus.byte_data == r_sum) ? S_DONE : S_ERR;
                end
            end
`endif
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Byte packing, word counting and the held write address/data.
    // The fourth byte goes straight into the write-data register so the
    // word is presented during the single WRITE cycle and held afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_len      <= '0;
            r_word_cnt <= '0;
            r_byte_idx <= '0;
            r_word_lo  <= '0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_sum      <= '0;
`endif
        end else begin
            if (w_can_start && !w_len_bad) begin
                r_len      <= bus.len_words;
                r_word_cnt <= '0;
                r_byte_idx <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                r_sum      <= '0;
`endif
            end
            if ((r_state == S_LOAD) && w_xfer) begin
                r_byte_idx <= r_byte_idx + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                r_sum      <= r_sum + bus.byte_data;
`endif
                case (r_byte_idx)
                    2'd0: r_word_lo[7:0]   <= bus.byte_data;
                    2'd1: r_word_lo[15:8]  <= bus.byte_data;
                    2'd2: r_word_lo[23:16] <= bus.byte_data;
                    default: begin
                        r_wr_data <= {bus.byte_data, r_word_lo};
                        r_wr_addr <= {22'd0, r_word_cnt, 2'b00};
                    end
                endcase
            end
            if (r_state == S_WRITE) begin
                r_word_cnt <= r_word_cnt + 8'd1;
            end
        end
    end

    assign bus.byte_ready = w_byte_ready;
    assign bus.wr_en      = w_wr_en;
    assign bus.wr_addr    = r_wr_addr;
    assign bus.wr_data    = r_wr_data;
    assign bus.core_reset = w_core_reset;
    assign bus.busy       = w_busy;
    assign bus.done       = w_done;
    assign bus.error      = w_error;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed boot loads, rejected lengths,
// reset mid-load and randomized loads checked against a word-packing model.
module tb_imem_loader;

    localparam int MEM_BYTES = 32;
    localparam int MAX_WORDS = MEM_BYTES / 4;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    imem_loader_if lif ();

    imem_loader #(.MEM_BYTES(MEM_BYTES)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (lif.slave)
    );

    int checks   = 0;
    int failures = 0;

    logic [31:0] got_addr[$];
    logic [31:0] got_data[$];
    logic [7:0]  tx[$];

    // Record every write strobe seen by the instruction memory
    always @(negedge clk) begin
        if (lif.wr_en === 1'b1) begin
            got_addr.push_back(lif.wr_addr);
            got_data.push_back(lif.wr_data);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_byte_ready"}, 32'(lif.byte_ready), 32'd0);
        chk({tag, "_wr_en"},      32'(lif.wr_en),      32'd0);
        chk({tag, "_wr_addr"},    lif.wr_addr,         32'd0);
        chk({tag, "_wr_data"},    lif.wr_data,         32'd0);
        chk({tag, "_core_reset"}, 32'(lif.core_reset), 32'd1);
        chk({tag, "_busy"},       32'(lif.busy),       32'd0);
        chk({tag, "_done"},       32'(lif.done),       32'd0);
        chk({tag, "_error"},      32'(lif.error),      32'd0);
    endtask

    // Called at a negedge; returns at the negedge after the start edge
    task automatic pulse_start(input logic [7:0] len);
        lif.start     = 1'b1;
        lif.len_words = len;
        @(negedge clk);
        lif.start     = 1'b0;
        lif.len_words = 8'($urandom);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge
    task automatic send_byte(input logic [7:0] b, input int gap, output bit ok);
        lif.byte_valid = 1'b0;
        repeat (gap) begin
            lif.byte_data = 8'($urandom);
            @(negedge clk);
        end
        lif.byte_valid = 1'b1;
        lif.byte_data  = b;
        ok = 1'b0;
        for (int t = 0; t < 20 && !ok; t++) begin
            ok = lif.byte_ready;
            @(negedge clk);
        end
        lif.byte_valid = 1'b0;
        lif.byte_data  = 8'($urandom);
    endtask

    function automatic logic [31:0] model_word(input int i);
        return 32'(tx[4*i]) + (32'(tx[4*i+1]) << 8) +
               (32'(tx[4*i+2]) << 16) + (32'(tx[4*i+3]) << 24);
    endfunction

    function automatic logic [7:0] model_sum();
        logic [7:0] s = 8'd0;
        foreach (tx[i]) s = s + tx[i];
        return s;
    endfunction

    // Full load of tx[] as len words; checks latency, outcome and all writes
    task automatic run_load(input logic [7:0] len, input int maxgap,
                            input bit mid_start, input bit bad_cks);
        bit ok;
        bit expect_ok;
        got_addr.delete();
        got_data.delete();
        pulse_start(len);
        chk("start_busy",       32'(lif.busy),       32'd1);
        chk("start_core_reset", 32'(lif.core_reset), 32'd1);
        chk("start_done_clr",   32'(lif.done),       32'd0);
        chk("start_error_clr",  32'(lif.error),      32'd0);
        for (int i = 0; i < tx.size(); i++) begin
            if (mid_start && i == 2) begin
                lif.start     = 1'b1;
                lif.len_words = 8'd0;
                @(negedge clk);
                lif.start     = 1'b0;
            end
            send_byte(tx[i], $urandom_range(0, maxgap), ok);
            if (!ok) begin
                chk("byte_accept_timeout", 32'd0, 32'd1);
                return;
            end
        end
        chk("wr_en_after_last_byte", 32'(lif.wr_en), 32'd1);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(bad_cks ? model_sum() + 8'd1 : model_sum(), 0, ok);
        chk("checksum_accept", 32'(ok), 32'd1);
        expect_ok = !bad_cks;
`else
        @(negedge clk);
        expect_ok = 1'b1;
`endif
        chk("end_done",       32'(lif.done),       32'(expect_ok));
        chk("end_error",      32'(lif.error),      32'(!expect_ok));
        chk("end_core_reset", 32'(lif.core_reset), 32'(!expect_ok));
        chk("end_busy",       32'(lif.busy),       32'd0);
        chk("end_wr_en",      32'(lif.wr_en),      32'd0);
        @(negedge clk);
        chk("write_count", 32'(got_addr.size()), 32'(len));
        for (int i = 0; i < got_addr.size() && i < int'(len); i++) begin
            chk($sformatf("write%0d_addr", i), got_addr[i], 32'(4 * i));
            chk($sformatf("write%0d_data", i), got_data[i], model_word(i));
        end
        chk("hold_wr_addr", lif.wr_addr, 32'(4 * (int'(len) - 1)));
        chk("hold_wr_data", lif.wr_data, model_word(int'(len) - 1));
    endtask

    // Rejected length: immediate error, no handshake, no writes
    task automatic run_bad(input logic [7:0] len);
        got_addr.delete();
        got_data.delete();
        lif.byte_valid = 1'b1;
        lif.byte_data  = 8'h55;
        pulse_start(len);
        for (int c = 0; c < 3; c++) begin
            chk("bad_error",      32'(lif.error),      32'd1);
            chk("bad_core_reset", 32'(lif.core_reset), 32'd1);
            chk("bad_byte_ready", 32'(lif.byte_ready), 32'd0);
            chk("bad_busy",       32'(lif.busy),       32'd0);
            chk("bad_done",       32'(lif.done),       32'd0);
            @(negedge clk);
        end
        lif.byte_valid = 1'b0;
        chk("bad_no_write", 32'(got_addr.size()), 32'd0);
    endtask

    initial begin
        bit ok;
        logic [7:0] len;
        reset          = 1'b1;
        lif.start      = 1'b0;
        lif.len_words  = 8'd0;
        lif.byte_valid = 1'b0;
        lif.byte_data  = 8'd0;
        repeat (3) @(negedge clk);
        check_reset_values("por");
        reset = 1'b0;

        // T1: one word
        tx = '{8'h33, 8'h03, 8'h94, 8'h00};
        run_load(8'd1, 0, 1'b0, 1'b0);

        // T2: two words back to back
        tx = '{8'h33, 8'h03, 8'h94, 8'h00, 8'hB3, 8'h03, 8'h39, 8'h41};
        run_load(8'd2, 0, 1'b0, 1'b0);

        // T3: same stream with idle gaps
        run_load(8'd2, 3, 1'b0, 1'b0);

        // T4: zero length and over-size length
        run_bad(8'd0);
        run_bad(8'(MAX_WORDS + 1));

        // T5: reset after two bytes of word 0
        got_addr.delete();
        got_data.delete();
        pulse_start(8'd1);
        send_byte(8'h33, 0, ok);
        send_byte(8'h03, 0, ok);
        reset = 1'b1;
        @(negedge clk);
        check_reset_values("midreset");
        reset = 1'b0;
        lif.byte_valid = 1'b1;
        lif.byte_data  = 8'h94;
        repeat (3) begin
            chk("midreset_no_ready", 32'(lif.byte_ready), 32'd0);
            @(negedge clk);
        end
        lif.byte_valid = 1'b0;
        chk("midreset_no_write", 32'(got_addr.size()), 32'd0);
        tx = '{8'h33, 8'h03, 8'h94, 8'h00};
        run_load(8'd1, 0, 1'b0, 1'b0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // T6: wrong checksum keeps the core in reset
        run_load(8'd1, 0, 1'b0, 1'b1);
`endif

        // Randomized loads, including a start pulse while busy
        for (int r = 0; r < 6; r++) begin
            len = 8'($urandom_range(1, MAX_WORDS));
            tx.delete();
            for (int i = 0; i < 4 * int'(len); i++) tx.push_back(8'($urandom));
            run_load(len, 3, r == 1, r == 3);
        end
        run_bad(8'($urandom_range(MAX_WORDS + 1, 255)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

`ifndef IMEM_LOADER_CHECKSUM_EN
    // bad_cks only has meaning when the checksum byte exists
`endif

endmodule
